// File: rtl/data_mem_pkg.sv
// Shared constants for the MEM-stage data RAM: access-size encodings,
// write-lane boundaries, default depth and dump-engine state encoding.
package data_mem_pkg;

    // One-hot access sizes as produced by the memory controller
    localparam logic [2:0] SIZE_BYTE = 3'b001;
    localparam logic [2:0] SIZE_HALF = 3'b010;
    localparam logic [2:0] SIZE_WORD = 3'b100;

    // Upper bit of the low-aligned lanes written by sub-word stores (7:0 and 15:0)
    localparam int LANE_BYTE_MSB = 7;
    localparam int LANE_HALF_MSB = 15;

    localparam int DEFAULT_N_ELEMENTS = 128;

    // Dump engine state encoding
    typedef logic [1:0] dump_state_t;
    localparam dump_state_t ST_IDLE = 2'b00;
    localparam dump_state_t ST_SEND = 2'b01;
    localparam dump_state_t ST_DONE = 2'b10;

    // True only for the three legal one-hot size codes
    function automatic logic is_onehot_size(input logic [2:0] size);
        return (size == SIZE_BYTE) || (size == SIZE_HALF) || (size == SIZE_WORD);
    endfunction

endpackage

// File: rtl/data_memory_if.sv
// Bus bundle between the data RAM (slave) and its users (master): the
// pipeline access port from the memory controller and the dump stream
// towards the debug unit.
interface data_memory_if #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = $clog2(data_mem_pkg::DEFAULT_N_ELEMENTS)
);
    // Pipeline port
    logic               i_mem_write;
    logic [NB_ADDR-1:0] i_addr;
    logic [2:0]         i_size;
    logic [NB_DATA-1:0] i_data_write;
    logic [NB_DATA-1:0] o_data_read;
    // Dump port
    logic               i_dump_req;
    logic               i_dump_ready;
    logic               o_dump_valid;
    logic [NB_ADDR-1:0] o_dump_addr;
    logic [NB_DATA-1:0] o_dump_data;
    logic               o_dump_done;
    logic               o_busy;
    logic               o_size_err;

    modport master (
        output i_mem_write, i_addr, i_size, i_data_write, i_dump_req, i_dump_ready,
        input  o_data_read, o_dump_valid, o_dump_addr, o_dump_data, o_dump_done,
               o_busy, o_size_err
    );

    modport slave (
        input  i_mem_write, i_addr, i_size, i_data_write, i_dump_req, i_dump_ready,
        output o_data_read, o_dump_valid, o_dump_addr, o_dump_data, o_dump_done,
               o_busy, o_size_err
    );

endinterface

// File: rtl/data_mem_dump_fsm.sv
// Sequential dump engine: walks a pointer over the whole array and
// presents one word per accepted valid/ready beat, then pulses done.
module data_mem_dump_fsm
    import data_mem_pkg::*;
#(
    parameter  int N_ELEMENTS = DEFAULT_N_ELEMENTS,
    localparam int NB_ADDR    = $clog2(N_ELEMENTS)
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_dump_req,
    input  logic               i_dump_ready,
    output logic               o_dump_valid,
    output logic               o_dump_done,
    output logic               o_busy,
    output logic [NB_ADDR-1:0] o_ptr
);

    // Last word is found by explicit compare so the pointer never has to wrap
    localparam logic [NB_ADDR-1:0] LAST_PTR = NB_ADDR'(N_ELEMENTS - 1);

    dump_state_t        state_d, state_q;
    logic [NB_ADDR-1:0] ptr_d, ptr_q;

    // Next-state and pointer update
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (i_dump_req) begin
                    ptr_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (i_dump_ready) begin
                    if (ptr_q == LAST_PTR) begin
                        state_d = ST_DONE;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and pointer registers, synchronous reset
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Moore outputs decoded from the state register
    always_comb begin
        o_dump_valid = (state_q == ST_SEND);
        o_dump_done  = (state_q == ST_DONE);
        o_busy       = (state_q != ST_IDLE);
        o_ptr        = ptr_q;
    end

endmodule

// File: rtl/data_memory.sv
// Word-organised MEM-stage data RAM with low-lane sub-word writes,
// combinational read, sticky size-error flag and a full-array dump port.
// Build option: DATA_MEM_RESET_CLEAR_EN makes reset also zero every word
// (reset wins over a same-cycle write); without it the array keeps its
// contents across reset and stays inferable as distributed RAM.
module data_memory
    import data_mem_pkg::*;
#(
    parameter int NB_DATA    = 32,
    parameter int N_ELEMENTS = DEFAULT_N_ELEMENTS
) (
    input  logic          i_clock,
    input  logic          i_reset,
    data_memory_if.slave  bus
);

    localparam int NB_ADDR = $clog2(N_ELEMENTS);

    logic [NB_DATA-1:0] mem [N_ELEMENTS];

    logic               size_ok;
    logic               wr_en;
    logic [NB_DATA-1:0] lane_mask;
    logic [NB_DATA-1:0] wr_word;
    logic               size_err_d, size_err_q;
    logic [NB_ADDR-1:0] dump_ptr;

    // Lane selection and read-modify-write merge for the addressed word
    always_comb begin
        size_ok   = is_onehot_size(bus.i_size);
        wr_en     = bus.i_mem_write && size_ok;
        lane_mask = '0;
        case (bus.i_size)
            SIZE_BYTE: lane_mask[LANE_BYTE_MSB:0] = '1;
            SIZE_HALF: lane_mask[LANE_HALF_MSB:0] = '1;
            SIZE_WORD: lane_mask                  = '1;
            default:   lane_mask                  = '0;
        endcase
        wr_word    = (mem[bus.i_addr] & ~lane_mask) | (bus.i_data_write & lane_mask);
        size_err_d = size_err_q | (bus.i_mem_write && !size_ok);
    end

`ifdef DATA_MEM_RESET_CLEAR_EN
    // Array write; reset clears every word and overrides a pipeline write
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int unsigned k = 0; k < N_ELEMENTS; k++) begin
                mem[k[NB_ADDR-1:0]] <= '0;
            end
        end else if (wr_en) begin
            mem[bus.i_addr] <= wr_word;
        end
    end
`else
    // Array write; no reset so the array maps onto distributed RAM
    always_ff @(posedge i_clock) begin
        if (wr_en) begin
            mem[bus.i_addr] <= wr_word;
        end
    end
`endif

    // Sticky error flag for writes with an illegal size code
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            size_err_q <= 1'b0;
        end else begin
            size_err_q <= size_err_d;
        end
    end

    data_mem_dump_fsm #(
        .N_ELEMENTS (N_ELEMENTS)
    ) u_dump_fsm (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_dump_req   (bus.i_dump_req),
        .i_dump_ready (bus.i_dump_ready),
        .o_dump_valid (bus.o_dump_valid),
        .o_dump_done  (bus.o_dump_done),
        .o_busy       (bus.o_busy),
        .o_ptr        (dump_ptr)
    );

    // Combinational read ports into the array
    always_comb begin
        bus.o_data_read = mem[bus.i_addr];
        bus.o_dump_data = mem[dump_ptr];
        bus.o_dump_addr = dump_ptr;
        bus.o_size_err  = size_err_q;
    end

endmodule
